// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259 PIC host initiator.
// Holds the FSM encoding, init-step sequencing and ICW/OCW byte construction.
package pic_host_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_WR,
        ST_READY,
        ST_ACK1_LO,
        ST_ACK1_HI,
        ST_ACK2_LO,
        ST_ACK2_HI,
        ST_VEC_HOLD,
        ST_EOI_WR
    } state_t;

    // Sub-phase of a bus write: PRE keeps strobes high before CS_n drops.
    typedef enum logic [1:0] {
        WP_PRE,
        WP_SETUP,
        WP_LOW,
        WP_HIGH
    } wphase_t;

    typedef enum logic [2:0] {
        STEP_ICW1,
        STEP_ICW2,
        STEP_ICW3,
        STEP_ICW4,
        STEP_OCW1
    } init_step_t;

    typedef struct packed {
        logic       ltim;
        logic       sngl;
        logic       ic4;
        logic       aeoi;
        logic [4:0] vector_base;
        logic [7:0] cascade;
        logic [7:0] mask;
    } init_cfg_t;

    localparam logic [7:0] OCW2_NSEOI = 8'h20;
    localparam logic [7:0] ICW1_FIXED = 8'h10;
    localparam logic [7:0] ICW4_UPM   = 8'h01;

    // Returns {A0, data} for one initialization write.
    function automatic logic [8:0] init_word(input init_step_t step, input init_cfg_t cfg);
        logic [8:0] w;
        case (step)
            STEP_ICW1: w = {1'b0, ICW1_FIXED | {4'b0000, cfg.ltim, 1'b0, cfg.sngl, cfg.ic4}};
            STEP_ICW2: w = {1'b1, cfg.vector_base, 3'b000};
            STEP_ICW3: w = {1'b1, cfg.cascade};
            STEP_ICW4: w = {1'b1, 6'b000000, cfg.aeoi, 1'b0} | {1'b0, ICW4_UPM};
            default:   w = {1'b1, cfg.mask};
        endcase
        return w;
    endfunction

    function automatic init_step_t next_step(input init_step_t step, input init_cfg_t cfg);
        init_step_t n;
        case (step)
            STEP_ICW1: n = STEP_ICW2;
            STEP_ICW2: n = !cfg.sngl ? STEP_ICW3 : (cfg.ic4 ? STEP_ICW4 : STEP_OCW1);
            STEP_ICW3: n = cfg.ic4 ? STEP_ICW4 : STEP_OCW1;
            default:   n = STEP_OCW1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bus_strobe_timer.sv
// Phase timer shared by write and INTA cycles: load starts a low or high phase,
// phase_done flags its last cycle; the count saturates there instead of wrapping.
module bus_strobe_timer #(
    parameter int PULSE_WIDTH = 2,
    parameter int RECOVERY    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_high,
    output logic phase_done
);

    localparam int MAX_LEN = (PULSE_WIDTH > RECOVERY) ? PULSE_WIDTH : RECOVERY;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(RECOVERY - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] last;
    logic          high_phase;

    assign last       = high_phase ? HIGH_LAST : LOW_LAST;
    assign phase_done = (count == last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            high_phase <= 1'b0;
        end else if (load) begin
            count      <= '0;
            high_phase <= load_high;
        end else if (count != last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pic_host_interface.sv
// CPU-side 8259 initiator: programs ICW1..ICW4/OCW1, runs the two-pulse INTA cycle and
// issues non-specific EOI; outputs registered, vector held until vector_ready.
module pic_host_interface
    import pic_host_pkg::*;
#(
    parameter int PULSE_WIDTH = 2,
    parameter int RECOVERY    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_init,
    input  logic       cfg_ltim,
    input  logic       cfg_sngl,
    input  logic       cfg_ic4,
    input  logic       cfg_aeoi,
    input  logic [4:0] cfg_vector_base,
    input  logic [7:0] cfg_cascade,
    input  logic [7:0] cfg_mask,
    input  logic       eoi_request,
    input  logic       vector_ready,
    input  logic       interrupt,
    input  logic [7:0] data_bus_in,
    output logic       chip_select_n,
    output logic       write_enable_n,
    output logic       address,
    output logic [7:0] data_bus_out,
    output logic       data_bus_io,
    output logic       interrupt_acknowledge_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       init_done,
    output logic       busy
);

    state_t     state, state_nxt;
    wphase_t    wphase, wphase_nxt;
    init_step_t step, step_nxt;
    init_cfg_t  cfg;
    logic       eoi_pending;

    logic       tmr_load, tmr_load_high, phase_done;
    logic       capture, init_finish, eoi_start;

    logic       cs_n_d, wr_n_d, a0_d, io_d, inta_n_d, vv_d, busy_d, done_d;
    logic [7:0] dout_d;
    logic [8:0] word_nxt;

    bus_strobe_timer #(
        .PULSE_WIDTH (PULSE_WIDTH),
        .RECOVERY    (RECOVERY)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_high  (tmr_load_high),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= ST_IDLE;
            wphase                  <= WP_PRE;
            step                    <= STEP_ICW1;
            cfg                     <= '0;
            eoi_pending             <= 1'b0;
            vector                  <= 8'h00;
            chip_select_n           <= 1'b1;
            write_enable_n          <= 1'b1;
            address                 <= 1'b0;
            data_bus_out            <= 8'h00;
            data_bus_io             <= 1'b0;
            interrupt_acknowledge_n <= 1'b1;
            vector_valid            <= 1'b0;
            init_done               <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            state  <= state_nxt;
            wphase <= wphase_nxt;
            step   <= step_nxt;
            if (start_init) begin
                cfg <= '{ltim: cfg_ltim, sngl: cfg_sngl, ic4: cfg_ic4, aeoi: cfg_aeoi,
                         vector_base: cfg_vector_base, cascade: cfg_cascade, mask: cfg_mask};
            end
            // Requests arriving while one is pending collapse into the same EOI.
            if (start_init || eoi_start) begin
                eoi_pending <= 1'b0;
            end else if (eoi_request && state != ST_IDLE) begin
                eoi_pending <= 1'b1;
            end
            if (capture) begin
                vector <= data_bus_in;
            end
            chip_select_n           <= cs_n_d;
            write_enable_n          <= wr_n_d;
            address                 <= a0_d;
            data_bus_out            <= dout_d;
            data_bus_io             <= io_d;
            interrupt_acknowledge_n <= inta_n_d;
            vector_valid            <= vv_d;
            init_done               <= done_d;
            busy                    <= busy_d;
        end
    end

    always_comb begin
        state_nxt     = state;
        wphase_nxt    = wphase;
        step_nxt      = step;
        tmr_load      = 1'b0;
        tmr_load_high = 1'b0;
        capture       = 1'b0;
        init_finish   = 1'b0;
        eoi_start     = 1'b0;
        if (start_init) begin
            state_nxt  = ST_INIT_WR;
            wphase_nxt = WP_PRE;
            step_nxt   = STEP_ICW1;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_READY: begin
                    if (eoi_pending) begin
                        state_nxt  = ST_EOI_WR;
                        wphase_nxt = WP_SETUP;
                        eoi_start  = 1'b1;
                    end else if (interrupt) begin
                        state_nxt = ST_ACK1_LO;
                        tmr_load  = 1'b1;
                    end
                end
                ST_INIT_WR, ST_EOI_WR: begin
                    case (wphase)
                        WP_PRE:   wphase_nxt = WP_SETUP;
                        WP_SETUP: begin
                            wphase_nxt = WP_LOW;
                            tmr_load   = 1'b1;
                        end
                        WP_LOW: begin
                            if (phase_done) begin
                                wphase_nxt    = WP_HIGH;
                                tmr_load      = 1'b1;
                                tmr_load_high = 1'b1;
                            end
                        end
                        default: begin
                            if (phase_done) begin
                                wphase_nxt = WP_PRE;
                                if (state == ST_EOI_WR || step == STEP_OCW1) begin
                                    state_nxt   = ST_READY;
                                    init_finish = (state == ST_INIT_WR);
                                end else begin
                                    step_nxt = next_step(step, cfg);
                                end
                            end
                        end
                    endcase
                end
                ST_ACK1_LO: begin
                    if (phase_done) begin
                        state_nxt     = ST_ACK1_HI;
                        tmr_load      = 1'b1;
                        tmr_load_high = 1'b1;
                    end
                end
                ST_ACK1_HI: begin
                    if (phase_done) begin
                        state_nxt = ST_ACK2_LO;
                        tmr_load  = 1'b1;
                    end
                end
                ST_ACK2_LO: begin
                    if (phase_done) begin
                        state_nxt     = ST_ACK2_HI;
                        tmr_load      = 1'b1;
                        tmr_load_high = 1'b1;
                        capture       = 1'b1;
                    end
                end
                ST_ACK2_HI: begin
                    if (phase_done) begin
                        state_nxt = ST_VEC_HOLD;
                    end
                end
                ST_VEC_HOLD: begin
                    if (vector_ready) begin
                        state_nxt = ST_READY;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the pins line up with the state register.
    always_comb begin
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a0_d     = 1'b0;
        dout_d   = 8'h00;
        io_d     = 1'b0;
        inta_n_d = 1'b1;
        vv_d     = (state_nxt == ST_VEC_HOLD);
        busy_d   = !(state_nxt == ST_IDLE || state_nxt == ST_READY);
        done_d   = init_done;
        if (start_init) begin
            done_d = 1'b0;
        end else if (init_finish) begin
            done_d = 1'b1;
        end
        word_nxt = (state_nxt == ST_EOI_WR) ? {1'b0, OCW2_NSEOI} : init_word(step_nxt, cfg);
        case (state_nxt)
            ST_INIT_WR, ST_EOI_WR: begin
                if (wphase_nxt != WP_PRE) begin
                    cs_n_d = 1'b0;
                    io_d   = 1'b1;
                    a0_d   = word_nxt[8];
                    dout_d = word_nxt[7:0];
                    wr_n_d = (wphase_nxt != WP_LOW);
                end
            end
            ST_ACK1_LO, ST_ACK2_LO: inta_n_d = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pic_host_interface.sv
// Directed bench for pic_host_interface with a small PIC pin model and bus-write monitor.
module tb_pic_host_interface;

    localparam int CLK_PERIOD = 10;
    localparam int PW         = 2;

    typedef struct packed {
        logic            ltim;
        logic            sngl;
        logic            ic4;
        logic            aeoi;
        logic [4:0]      base;
        logic [7:0]      casc;
        logic [7:0]      mask;
        logic [2:0]      n;
        logic [4:0][8:0] w;
    } icfg_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_init, eoi_request, vector_ready, interrupt;
    logic       cfg_ltim, cfg_sngl, cfg_ic4, cfg_aeoi;
    logic [4:0] cfg_vector_base;
    logic [7:0] cfg_cascade, cfg_mask, data_bus_in, data_bus_out, vector, pic_vec;
    logic       chip_select_n, write_enable_n, address, data_bus_io;
    logic       interrupt_acknowledge_n, vector_valid, init_done, busy;

    icfg_t cfgs[3];
    icfg_t cur;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] wr_log[$];
    int         wr_w[$];
    int         inta_w[$];
    int         inta_falls = 0;
    int         inta_base  = 0;
    int         vv_rises   = 0;
    int         cs_viol    = 0;
    time        wr_t0, inta_t0, last_wr_t, last_inta_t;

    always #(CLK_PERIOD / 2) clk = ~clk;

    assign cfg_ltim        = cur.ltim;
    assign cfg_sngl        = cur.sngl;
    assign cfg_ic4         = cur.ic4;
    assign cfg_aeoi        = cur.aeoi;
    assign cfg_vector_base = cur.base;
    assign cfg_cascade     = cur.casc;
    assign cfg_mask        = cur.mask;

    // PIC drives the vector only during the second INTA pulse of each pair.
    assign data_bus_in = (!interrupt_acknowledge_n && (inta_falls - inta_base) > 0 &&
                          ((inta_falls - inta_base) % 2 == 0)) ? pic_vec : 8'hFF;

    pic_host_interface dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_init              (start_init),
        .cfg_ltim                (cfg_ltim),
        .cfg_sngl                (cfg_sngl),
        .cfg_ic4                 (cfg_ic4),
        .cfg_aeoi                (cfg_aeoi),
        .cfg_vector_base         (cfg_vector_base),
        .cfg_cascade             (cfg_cascade),
        .cfg_mask                (cfg_mask),
        .eoi_request             (eoi_request),
        .vector_ready            (vector_ready),
        .interrupt               (interrupt),
        .data_bus_in             (data_bus_in),
        .chip_select_n           (chip_select_n),
        .write_enable_n          (write_enable_n),
        .address                 (address),
        .data_bus_out            (data_bus_out),
        .data_bus_io             (data_bus_io),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .vector                  (vector),
        .vector_valid            (vector_valid),
        .init_done               (init_done),
        .busy                    (busy)
    );

    always @(negedge write_enable_n) begin
        wr_t0     = $time;
        last_wr_t = $time;
        wr_log.push_back({address, data_bus_out});
    end

    always @(posedge write_enable_n) begin
        if (!reset) wr_w.push_back(int'(($time - wr_t0) / CLK_PERIOD));
    end

    always @(negedge interrupt_acknowledge_n) begin
        inta_falls  = inta_falls + 1;
        inta_t0     = $time;
        last_inta_t = $time;
    end

    always @(posedge interrupt_acknowledge_n) begin
        if (!reset) inta_w.push_back(int'(($time - inta_t0) / CLK_PERIOD));
    end

    always @(posedge vector_valid) vv_rises = vv_rises + 1;

    always @(negedge clk) begin
        if (!reset && !interrupt_acknowledge_n && (!chip_select_n || data_bus_io)) cs_viol = cs_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_vector();
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
    endtask

    initial begin
        #(CLK_PERIOD * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, wwb, fb, iwb, vr, cs0;

        cfgs[0] = '{ltim: 1'b0, sngl: 1'b1, ic4: 1'b1, aeoi: 1'b0, base: 5'h08, casc: 8'h00,
                    mask: 8'hFB, n: 3'd4, w: {9'h013, 9'h140, 9'h101, 9'h1FB, 9'h000}};
        cfgs[1] = '{ltim: 1'b1, sngl: 1'b0, ic4: 1'b0, aeoi: 1'b0, base: 5'h1F, casc: 8'h04,
                    mask: 8'h5A, n: 3'd4, w: {9'h018, 9'h1F8, 9'h104, 9'h15A, 9'h000}};
        cfgs[2] = '{ltim: 1'b0, sngl: 1'b0, ic4: 1'b1, aeoi: 1'b1, base: 5'h10, casc: 8'h81,
                    mask: 8'h00, n: 3'd5, w: {9'h011, 9'h180, 9'h181, 9'h103, 9'h100}};
        cur          = cfgs[0];
        reset        = 1'b1;
        start_init   = 1'b0;
        eoi_request  = 1'b0;
        vector_ready = 1'b0;
        interrupt    = 1'b0;
        pic_vec      = 8'h00;

        repeat (3) tick();
        chk("rst_cs_n", chip_select_n, 1);
        chk("rst_wr_n", write_enable_n, 1);
        chk("rst_inta_n", interrupt_acknowledge_n, 1);
        chk("rst_io", data_bus_io, 0);
        chk("rst_dout", data_bus_out, 0);
        chk("rst_vector", vector, 0);
        chk("rst_vv", vector_valid, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        inta_base = inta_falls;
        cs0       = cs_viol;

        // IDLE ignores interrupt and EOI requests.
        wb = wr_log.size();
        fb = inta_falls;
        interrupt   = 1'b1;
        eoi_request = 1'b1;
        tick();
        eoi_request = 1'b0;
        repeat (8) tick();
        chk("idle_no_inta", inta_falls - fb, 0);
        chk("idle_no_wr", wr_log.size() - wb, 0);
        chk("idle_busy", busy, 0);
        interrupt = 1'b0;
        tick();

        for (int k = 0; k < 3; k++) begin
            cur = cfgs[k];
            wb  = wr_log.size();
            wwb = wr_w.size();
            start_init = 1'b1;
            tick();
            start_init = 1'b0;
            chk("init_strobe_cs", chip_select_n, 1);
            chk("init_clr_done", init_done, 0);
            chk("init_busy", busy, 1);
            for (int i = 0; i < 200 && !init_done; i++) tick();
            chk("init_done", init_done, 1);
            chk("init_wr_count", wr_log.size() - wb, int'(cur.n));
            for (int i = 0; i < int'(cur.n); i++) begin
                chk("init_word", (wr_log.size() > wb + i) ? wr_log[wb + i] : 9'h1FF, cur.w[4 - i]);
                chk("init_wr_width", (wr_w.size() > wwb + i) ? wr_w[wwb + i] : -1, PW);
            end
            tick();
            chk("init_idle_cs", chip_select_n, 1);
            chk("init_idle_busy", busy, 0);
        end

        // INTA: two pulses, vector captured on the second, held until accepted.
        fb  = inta_falls;
        iwb = inta_w.size();
        pic_vec   = 8'h42;
        interrupt = 1'b1;
        for (int i = 0; i < 60 && !vector_valid; i++) tick();
        chk("inta_vv_set", vector_valid, 1);
        chk("inta_vector", vector, 8'h42);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("inta_vv_hold", vector_valid, 1);
        end
        chk("inta_pulses", inta_falls - fb, 2);
        chk("inta_w1", (inta_w.size() > iwb) ? inta_w[iwb] : -1, PW);
        chk("inta_w2", (inta_w.size() > iwb + 1) ? inta_w[iwb + 1] : -1, PW);
        interrupt = 1'b0;
        accept_vector();
        chk("inta_vv_drop", vector_valid, 0);
        repeat (10) tick();
        chk("inta_no_third", inta_falls - fb, 2);
        chk("inta_busy_ready", busy, 0);
        chk("inta_cs_quiet", cs_viol - cs0, 0);

        // EOI requested mid-INTA is written once after the vector is accepted.
        fb = inta_falls;
        wb = wr_log.size();
        pic_vec   = 8'h37;
        interrupt = 1'b1;
        for (int i = 0; i < 40 && interrupt_acknowledge_n; i++) tick();
        eoi_request = 1'b1;
        tick();
        eoi_request = 1'b0;
        tick();
        tick();
        eoi_request = 1'b1;
        tick();
        eoi_request = 1'b0;
        for (int i = 0; i < 60 && !vector_valid; i++) tick();
        chk("eoi_vector", vector, 8'h37);
        chk("eoi_not_yet", wr_log.size() - wb, 0);
        accept_vector();
        for (int i = 0; i < 60 && (inta_falls - fb) < 3; i++) tick();
        chk("eoi_third_inta", inta_falls - fb, 3);
        chk("eoi_wr_count", wr_log.size() - wb, 1);
        chk("eoi_word", (wr_log.size() > wb) ? wr_log[wb] : 9'h1FF, 9'h020);
        chk("eoi_before_inta", (last_wr_t < last_inta_t), 1);
        // INT drops after ACK1 started: the sequence still completes.
        interrupt = 1'b0;
        for (int i = 0; i < 60 && !vector_valid; i++) tick();
        chk("eoi_late_vv", vector_valid, 1);
        chk("eoi_late_vector", vector, 8'h37);
        accept_vector();
        tick();
        chk("eoi_busy_ready", busy, 0);

        // start_init during ACK2_LO aborts the INTA cycle.
        fb = inta_falls;
        vr = vv_rises;
        wb = wr_log.size();
        interrupt = 1'b1;
        for (int i = 0; i < 60 && (inta_falls - fb) < 2; i++) tick();
        chk("abort_in_ack2", interrupt_acknowledge_n, 0);
        start_init = 1'b1;
        interrupt  = 1'b0;
        tick();
        start_init = 1'b0;
        chk("abort_inta_hi", interrupt_acknowledge_n, 1);
        chk("abort_vv", vector_valid, 0);
        chk("abort_init_clr", init_done, 0);
        for (int i = 0; i < 200 && !init_done; i++) tick();
        chk("abort_init_done", init_done, 1);
        chk("abort_vv_never", vv_rises - vr, 0);
        chk("abort_icw1", (wr_log.size() > wb) ? wr_log[wb] : 9'h1FF, 9'h011);

        // Asynchronous reset in the middle of a write cycle.
        cur = cfgs[0];
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        for (int i = 0; i < 20 && write_enable_n; i++) tick();
        chk("rstw_in_write", write_enable_n, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_wr_n", write_enable_n, 1);
        chk("rstw_cs_n", chip_select_n, 1);
        chk("rstw_init_done", init_done, 0);
        chk("rstw_io", data_bus_io, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("rstw_busy", busy, 0);
        chk("rstw_cs_idle", chip_select_n, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
